pipeline_stall_ctrl: RTL
========================

# pipeline_stall_ctrl

Central stall/flush sequencer for the five-stage cached core. It merges the load-use pause from hazard detection, EX-stage jump redirects, I-cache miss stalls and D-cache miss stalls into per-stage register enables and flushes. It tracks multi-cycle cache waits with an FSM, including abandoned I-cache fills after a redirect, plus a wait watchdog and performance counters. It sits beside the pipeline registers and drives every IF/ID, ID/EX, EX/MEM and MEM/WB register and the PC.

## Interface
- CNT_W, 32, width of stall_cnt and flush_cnt (saturating)
- TIMEOUT, 255, max consecutive wait cycles before error (1..2^16-1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- load_use_pause  in  1  load-use hazard, instruction in ID must hold
- ex_jump_flag  in  1  taken branch/jump resolved in EX
- if_miss  in  1  I-cache miss on current fetch
- if_ready  in  1  I-cache fill complete (1-cycle pulse)
- mem_req  in  1  MEM-stage instruction accesses D-cache
- mem_ready  in  1  D-cache access complete this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load bubble (NOP) into register
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  jump redirects taken
- timeout_err  out  1  sticky watchdog error

## Operation
- dstall = mem_req & !mem_ready; istall = if_miss & !if_ready.
- Output priority in RUN, D_WAIT, I_WAIT; first match wins. Outputs not listed are enable=1, flush=0.
  1. dstall: pc_en=if_id_en=id_ex_en=ex_mem_en=0; mem_wb_flush=1.
  2. ex_jump_flag: if_id_flush=1, id_ex_flush=1, pc_en=1. Overrides load_use and istall.
  3. load_use_pause: pc_en=0, if_id_en=0, id_ex_flush=1.
  4. istall: pc_en=0, if_id_flush=1.
  5. Otherwise: free run.
- I_DROP: a redirect arrived while a fill was in flight, and the stale fill must drain. The I-side is forced to the istall case: pc_en=0, if_id_flush=1. Rules 1–3 still apply with priority, except that rule 2 keeps pc_en=0.
- ERR: all enables 0, all flushes 0, timeout_err=1.
- Next state from RUN, D_WAIT and I_WAIT, using the same priority:
  - dstall goes to D_WAIT.
  - Else ex_jump_flag & istall goes to I_DROP.
  - Else istall & !load_use_pause goes to I_WAIT.
  - Else go to RUN.
- I_DROP goes to RUN on if_ready. The if_ready cycle itself is still a bubble, and the fill data is discarded. If dstall is also active, go to D_WAIT instead.
- wait_cnt: increments each cycle in D_WAIT, I_WAIT or I_DROP. Cleared on entering RUN. At wait_cnt==TIMEOUT, go to ERR. ERR is exited only by reset.
- stall_cnt increments on every cycle with pc_en=0 (ERR included). flush_cnt increments on every cycle rule 2 fires. Both saturate at all-ones.

## Timing
- Enables and flushes are combinational from state and inputs: zero latency, they act on the same clock edge.
- State, wait_cnt, counters and timeout_err update on the rising edge of clk.
- Reset (rst_n=0, async):
  - State RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, timeout_err=0.
  - While rst_n=0, all enables and flushes are forced to 0.
- mem_req and mem_ready high in the same cycle: no stall and no state change.
- Simultaneous dstall and ex_jump_flag: the jump is held, not lost. The EX/MEM freeze keeps EX stable, so the jump re-asserts after mem_ready.
- if_miss and if_ready in the same cycle: istall=0, no stall.
- Reset mid-wait: immediate return to RUN; any in-flight cache fill is not tracked after reset.

## Test plan
- Load-use: load_use_pause=1 for 1 cycle → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cnt=1; state stays RUN.
- D-cache miss: mem_req=1 with mem_ready=0 for 4 cycles, then 1 → four cycles with pc_en=ex_mem_en=0 and mem_wb_flush=1; D_WAIT for 4 cycles; RUN after the ready edge; stall_cnt=4.
- Redirect during I-miss: istall for 2 cycles, then ex_jump_flag=1 → if_id_flush and id_ex_flush asserted, state goes to I_DROP. if_ready 3 cycles later → bubble that cycle, then RUN; flush_cnt=1.
- Priority: dstall, ex_jump_flag and load_use_pause all 1 → only rule 1 outputs. Drop dstall → rule 2 outputs; flush_cnt increments once.
- Watchdog with TIMEOUT=8: mem_req=1, mem_ready=0 held → ERR after 8 wait cycles; timeout_err=1 stays set with mem_ready=1; cleared only by pulsing rst_n low.
- Async reset asserted mid-D_WAIT, between edges → outputs drop to 0 immediately; counters read 0; RUN after rst_n goes high.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the five-stage cached core.
// It merges four hazard sources into per-stage register enables and flushes:
//   - load-use pause
//   - EX-stage jump redirects
//   - I-cache miss stalls
//   - D-cache miss stalls
// Multi-cycle cache waits are tracked by an FSM, and a watchdog bounds how long
// a wait may last.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_RUN  | no cache wait outstanding
// ST_D_WAIT | waiting on a D-cache access
// ST_I_WAIT | waiting on an I-cache fill for the current fetch
// ST_I_DROP | redirect hit during a fill; the stale fill is drained, then dropped
// ST_ERR  | wait watchdog expired; pipeline frozen until reset
module pipeline_stall_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_pause,
  input  logic             ex_jump_flag,
  input  logic             if_miss,
  input  logic             if_ready,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_D_WAIT = 3'd1,
    ST_I_WAIT = 3'd2,
    ST_I_DROP = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] wait_inc;
  logic        dstall, istall, in_wait;
  logic        jump_fire;

  assign dstall   = mem_req & ~mem_ready;
  assign istall   = if_miss & ~if_ready;
  assign in_wait  = (state_q == ST_D_WAIT) || (state_q == ST_I_WAIT) ||
                    (state_q == ST_I_DROP);
  assign wait_inc = wait_cnt_q + 16'd1;

  // State and wait-cycle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state selection.
  // The watchdog overrides the normal transition once the wait budget is used up.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN, ST_D_WAIT, ST_I_WAIT: begin
        if (dstall)                          state_d = ST_D_WAIT;
        else if (ex_jump_flag && istall)     state_d = ST_I_DROP;
        else if (istall && !load_use_pause)  state_d = ST_I_WAIT;
        else                                 state_d = ST_RUN;
      end
      ST_I_DROP: begin
        if (if_ready) state_d = dstall ? ST_D_WAIT : ST_RUN;
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
    if (in_wait) begin
      wait_cnt_d = wait_inc;
      if (wait_inc == TIMEOUT_L) state_d = ST_ERR;
    end
    if (state_d == ST_RUN) wait_cnt_d = '0;
  end

  // Enables and flushes, combinational from state and hazard inputs.
  // Reset forces every enable and flush low.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    jump_fire    = 1'b0;
    if (state_q == ST_ERR) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (dstall) begin
      // EX/MEM stays frozen here, so a pending jump in EX is preserved for later.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_jump_flag) begin
      // While a stale fill drains, the PC must not advance past the redirect target.
      jump_fire   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pc_en       = (state_q != ST_I_DROP);
    end else if (load_use_pause) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (istall || state_q == ST_I_DROP) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      jump_fire    = 1'b0;
    end
  end

  // Saturating performance counters: PC-stall cycles and redirects taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (jump_fire && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign timeout_err = (state_q == ST_ERR);

endmodule
